// File: rtl/cordic_iter_engine_if.sv
// Controller-facing handshake of cordic_iter_engine: start, mode and operands in; busy, done and results out.
interface cordic_iter_engine_if #(
    parameter int unsigned WIDTH = 32
);
    logic                    start;
    logic [1:0]              mode;
    logic                    vectoring;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] z_in;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] z_out;

    modport master (
        output start, mode, vectoring, x_in, y_in, z_in,
        input  busy, done, x_out, y_out, z_out
    );

    modport slave (
        input  start, mode, vectoring, x_in, y_in, z_in,
        output busy, done, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine (circular/linear/hyperbolic, rotation/vectoring), one micro-rotation per cycle.
// Optional CORDIC_GAIN_COMP_EN adds a circular-mode gain-compensation cycle before DONE.
module cordic_iter_engine #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_ITER = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_iter_engine_if.slave  ctrl,
    output logic [4:0]           rom_index,
    output logic [1:0]           rom_mode,
    input  logic [31:0]          rom_data
);
    localparam int unsigned ZW     = WIDTH + 1;
    localparam logic [4:0]  K_LAST = 5'(N_ITER - 1);
    localparam logic [1:0]  M_CIRC = 2'b10;
    localparam logic [1:0]  M_HYP  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMP, S_DONE} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] x_q, y_q;
    logic signed [ZW-1:0]    z_q;
    logic                    vec_q, rep_q, busy_q, done_q;
    logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;

    logic signed [WIDTH-1:0] x_sh_c, y_sh_c, x_nx_c, y_nx_c;
    logic signed [ZW-1:0]    rom_ext_c, z_nx_c;
    logic                    d_pos_c, hold_c, last_c, to_comp_c;

    // One micro-rotation for the current shift index k (= rom_index)
    always_comb begin
        x_sh_c    = x_q >>> rom_index;
        y_sh_c    = y_q >>> rom_index;
        rom_ext_c = ZW'({1'b0, rom_data});
        d_pos_c   = vec_q ? y_q[WIDTH-1] : ~z_q[ZW-1];
        y_nx_c    = d_pos_c ? (y_q + x_sh_c) : (y_q - x_sh_c);
        z_nx_c    = d_pos_c ? (z_q - rom_ext_c) : (z_q + rom_ext_c);
        case (rom_mode)
            M_CIRC:  x_nx_c = d_pos_c ? (x_q - y_sh_c) : (x_q + y_sh_c);
            M_HYP:   x_nx_c = d_pos_c ? (x_q + y_sh_c) : (x_q - y_sh_c);
            default: x_nx_c = x_q;
        endcase
        // Hyperbolic convergence needs k=4 and k=13 executed twice
        hold_c = (rom_mode == M_HYP) && !rep_q && ((rom_index == 5'd4) || (rom_index == 5'd13));
        last_c = !hold_c && (rom_index == K_LAST);
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned        PW    = WIDTH + 32;
    localparam logic signed [31:0] INV_K = 32'sh4DBA76D4;

    logic signed [PW-1:0]    x_prod_c, y_prod_c;
    logic signed [WIDTH-1:0] x_comp_c, y_comp_c;

    // Scale by 1/K (Q1.31) to cancel the circular CORDIC gain
    always_comb begin
        x_prod_c  = PW'(x_q) * PW'(INV_K);
        y_prod_c  = PW'(y_q) * PW'(INV_K);
        x_comp_c  = WIDTH'(x_prod_c >>> 31);
        y_comp_c  = WIDTH'(y_prod_c >>> 31);
        to_comp_c = (rom_mode == M_CIRC);
    end
`else
    assign to_comp_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            vec_q     <= 1'b0;
            rep_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rom_index <= '0;
            rom_mode  <= '0;
            x_out_q   <= '0;
            y_out_q   <= '0;
            z_out_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (ctrl.start) begin
                        x_q       <= ctrl.x_in;
                        y_q       <= ctrl.y_in;
                        z_q       <= ZW'(ctrl.z_in);
                        vec_q     <= ctrl.vectoring;
                        rep_q     <= 1'b0;
                        rom_mode  <= (ctrl.mode == 2'b01) ? 2'b00 : ctrl.mode;
                        // Hyperbolic ROM entry 0 is unused, so that mode starts at k=1
                        rom_index <= (ctrl.mode == M_HYP) ? 5'd1 : 5'd0;
                        busy_q    <= 1'b1;
                        state     <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    x_q   <= x_nx_c;
                    y_q   <= y_nx_c;
                    z_q   <= z_nx_c;
                    rep_q <= hold_c;
                    if (last_c) begin
                        rom_index <= '0;
                        if (to_comp_c) begin
                            state <= S_COMP;
                        end else begin
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            x_out_q <= x_nx_c;
                            y_out_q <= y_nx_c;
                            z_out_q <= z_nx_c[WIDTH-1:0];
                        end
                    end else if (!hold_c) begin
                        rom_index <= rom_index + 5'd1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    state   <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    x_out_q <= x_comp_c;
                    y_out_q <= y_comp_c;
                    z_out_q <= z_q[WIDTH-1:0];
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ctrl.busy  = busy_q;
    assign ctrl.done  = done_q;
    assign ctrl.x_out = x_out_q;
    assign ctrl.y_out = y_out_q;
    assign ctrl.z_out = z_out_q;
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: directed vectors push expectations, a done-driven monitor checks them.
module tb_cordic_iter_engine;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned N_ITER = 24;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int          CIRC_LAT = 26;
    localparam logic [31:0] CROT_X   = 32'h40000000;
    localparam logic [31:0] CVEC_X   = 32'h2D413CCD;
`else
    localparam int          CIRC_LAT = 25;
    localparam logic [31:0] CROT_X   = 32'h26DD3B6A;
    localparam logic [31:0] CVEC_X   = 32'h4A861BCE;
`endif

    typedef struct {
        string       name;
        int          issue;
        int          lat;
        bit          chk;
        logic [31:0] x, y, z;
        int          tx, ty, tz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rom_index;
    logic [1:0]  rom_mode;
    logic [31:0] rom_data;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    bit          rec_en = 1'b0;
    logic [4:0]  seq[$];
    exp_t        sbq[$];

    cordic_iter_engine_if #(.WIDTH(WIDTH)) bus ();

    cordic_iter_engine #(.WIDTH(WIDTH), .N_ITER(N_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (bus),
        .rom_index (rom_index),
        .rom_mode  (rom_mode),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Angle-constant ROM: 45 deg = 0x10000000, linear 1.0 = 0x80000000
    function automatic logic [31:0] rom_fn(input logic [4:0] k, input logic [1:0] m);
        real t;
        real scale;
        t     = 1.0;
        scale = 1073741824.0 / 3.14159265358979;
        for (int i = 0; i < int'(k); i++) t = t / 2.0;
        if (m == 2'b10) return 32'($rtoi($atan(t) * scale + 0.5));
        if (m == 2'b11) begin
            if (k == 5'd0) return 32'h0;
            return 32'($rtoi($atanh(t) * scale + 0.5));
        end
        return 32'(64'h80000000 >> k);
    endfunction

    assign rom_data = rom_fn(rom_index, rom_mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int tol);
        int diff;
        diff = int'($signed(act - exp_v));
        if (diff < 0) diff = -diff;
        total++;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", name, act, exp_v, tol);
        end
    endtask

    function automatic exp_t mk(input string name, input int lat, input bit chk,
                                input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                                input int tx, input int ty, input int tz);
        exp_t e;
        e.name = name; e.issue = 0; e.lat = lat; e.chk = chk;
        e.x = x; e.y = y; e.z = z; e.tx = tx; e.ty = ty; e.tz = tz;
        return e;
    endfunction

    // Called at a negedge; start is sampled by the following posedge
    task automatic send(input logic [1:0] m, input logic v, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] z, input bit push, input exp_t e);
        bus.mode = m; bus.vectoring = v;
        bus.x_in = x; bus.y_in = y; bus.z_in = z;
        bus.start = 1'b1;
        e.issue = cyc;
        if (push) sbq.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_lat"}, 32'(cyc - e.issue), 32'(e.lat), 0);
                if (e.chk) begin
                    check({e.name, "_x"}, bus.x_out, e.x, e.tx);
                    check({e.name, "_y"}, bus.y_out, e.y, e.ty);
                    check({e.name, "_z"}, bus.z_out, e.z, e.tz);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rec_en && bus.busy) begin
            seq.push_back(rom_index);
            check("hyp_rom_mode", 32'(rom_mode), 32'd3, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          n;
        logic [4:0]  exp_seq[$];

        bus.start = 1'b0; bus.mode = 2'b00; bus.vectoring = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0, 0);
        check("rst_done", 32'(bus.done), 32'd0, 0);
        check("rst_x_out", bus.x_out, 32'd0, 0);
        check("rst_y_out", bus.y_out, 32'd0, 0);
        check("rst_z_out", bus.z_out, 32'd0, 0);
        check("rst_rom_index", 32'(rom_index), 32'd0, 0);
        check("rst_rom_mode", 32'(rom_mode), 32'd0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Circular rotation by 45 deg of a 1/K-prescaled unit vector
        send(2'b10, 1'b0, CROT_X, 32'h0, 32'h10000000, 1'b1,
             mk("circ_rot", CIRC_LAT, 1'b1, 32'h2D413CCD, 32'h2D413CCD, 32'h0, 192, 192, 64));
        wait_idle("circ_rot");

        // Circular vectoring of (0.5, 0.5): angle 45 deg, magnitude K*0.7071
        send(2'b10, 1'b1, 32'h20000000, 32'h20000000, 32'h0, 1'b1,
             mk("circ_vec", CIRC_LAT, 1'b1, CVEC_X, 32'h0, 32'h10000000, 96, 256, 64));
        wait_idle("circ_vec");

        // Linear 0.5*0.5: exact residual z = -256 units leaves y = 0x10000040
        send(2'b00, 1'b0, 32'h20000000, 32'h0, 32'h40000000, 1'b1,
             mk("lin_rot", 25, 1'b1, 32'h20000000, 32'h10000040, 32'hFFFFFF00, 0, 0, 0));
        // Start held with new operands through the run; only the DONE cycle may accept it
        bus.mode = 2'b10; bus.vectoring = 1'b0;
        bus.x_in = CROT_X; bus.y_in = 32'h0; bus.z_in = 32'h10000000;
        bus.start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        if (!bus.done) begin
            total++; bad++;
            $display("FAIL held_start_timeout: no done after %0d cycles", n);
        end
        e = mk("circ_after_done", CIRC_LAT, 1'b1, 32'h2D413CCD, 32'h2D413CCD, 32'h0, 192, 192, 64);
        e.issue = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle("held_start");

        // Mode 01 behaves as linear; a start pulse mid-run is ignored
        send(2'b01, 1'b0, 32'h20000000, 32'h0, 32'h40000000, 1'b1,
             mk("lin_mode01", 25, 1'b1, 32'h20000000, 32'h10000040, 32'hFFFFFF00, 0, 0, 0));
        repeat (5) @(negedge clk);
        bus.mode = 2'b11; bus.vectoring = 1'b1;
        bus.x_in = 32'h12345678; bus.y_in = 32'h07654321; bus.z_in = 32'h00005555;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle("lin_mode01");

        // Hyperbolic index sequence with repeated k=4 and k=13
        seq.delete();
        rec_en = 1'b1;
        send(2'b11, 1'b0, 32'h40000000, 32'h0, 32'h08000000, 1'b1,
             mk("hyp_rot", 26, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        wait_idle("hyp_rot");
        rec_en = 1'b0;
        for (int k = 1; k < int'(N_ITER); k++) begin
            exp_seq.push_back(5'(k));
            if (k == 4 || k == 13) exp_seq.push_back(5'(k));
        end
        check("hyp_len", 32'(seq.size()), 32'(exp_seq.size()), 0);
        for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
            check($sformatf("hyp_idx%0d", i), 32'(seq[i]), 32'(exp_seq[i]), 0);

        // Reset during RUN cycle 10: abort with no done, outputs cleared
        send(2'b10, 1'b0, CROT_X, 32'h0, 32'h10000000, 1'b0,
             mk("abort", CIRC_LAT, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0, 0);
        check("abort_done", 32'(bus.done), 32'd0, 0);
        check("abort_x_out", bus.x_out, 32'd0, 0);
        check("abort_y_out", bus.y_out, 32'd0, 0);
        check("abort_z_out", bus.z_out, 32'd0, 0);
        check("abort_rom_index", 32'(rom_index), 32'd0, 0);
        check("abort_rom_mode", 32'(rom_mode), 32'd0, 0);
        repeat (40) @(negedge clk);
        check("abort_still_idle", 32'(bus.busy), 32'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
